ysyx_23060278_mcore: RTL and testbench
======================================

# ysyx_23060278_mcore

Parametrised multi-cycle RV32I/RV32E core, the next generation of the single-cycle addi-only top. It fetches over a valid/ready instruction port and runs a small instruction set through an explicit state machine. It accesses data memory over a second valid/ready port. It holds its own PC, register file, decoder and ALU, and exposes halt, retire and debug register-read outputs for the simulation harness.

## Interface
- XLEN, 32: datapath and address width; only 32 is supported.
- NR_REGS, 32: register count; 32 selects RV32I, 16 selects RV32E.
- RESET_PC, 32'h8000_0000: PC loaded on reset.

- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- ifu_req_valid  out  1  fetch request valid.
- ifu_req_ready  in  1  fetch request accepted.
- ifu_addr  out  XLEN  fetch address; equals pc.
- ifu_rsp_valid  in  1  instruction returned; single-cycle pulse with no backpressure.
- ifu_inst  in  32  instruction word.
- lsu_req_valid  out  1  data request valid.
- lsu_req_ready  in  1  data request accepted.
- lsu_wen  out  1  1 = store, 0 = load.
- lsu_addr  out  XLEN  word address; bits [1:0] forced to 0.
- lsu_wdata  out  XLEN  store data.
- lsu_wmask  out  4  byte mask; 4'hF for stores, 4'h0 for loads.
- lsu_rsp_valid  in  1  load data valid or store complete; single-cycle pulse.
- lsu_rdata  in  XLEN  load data.
- pc  out  XLEN  PC of the instruction in flight.
- retire  out  1  one-cycle pulse when an instruction commits.
- halt  out  1  sticky after ebreak or illegal instruction.
- illegal  out  1  sticky; set when the halt cause is illegal.
- dbg_raddr  in  5  debug register index.
- dbg_rdata  out  XLEN  combinational read of register dbg_raddr; returns 0 for x0 and for indices ≥ NR_REGS.

## Operation
- Supported instructions: lui, auipc, jal, jalr, beq, bne, addi, add, sub, lw, sw, ebreak.
- Any other encoding is illegal.
- With NR_REGS=16, any rs1, rs2 or rd index ≥ 16 is illegal.
- States:
  - FETCH: ifu_req_valid=1. On ifu_req_ready go to IWAIT.
  - IWAIT: on ifu_rsp_valid, latch ifu_inst and go to EXEC.
  - EXEC: decode, read registers, compute ALU result and next PC.
    - Non-memory instruction: write back, update pc, pulse retire, go to FETCH.
    - lw/sw: go to MREQ.
    - ebreak or illegal: go to HALT without retiring.
  - MREQ: lsu_req_valid=1. On lsu_req_ready go to MWAIT.
  - MWAIT: on lsu_rsp_valid, write back for lw, update pc, pulse retire, go to FETCH.
  - HALT: absorbing; no requests are issued. Only rst leaves HALT.
- x0 always reads 0; writes to x0 are dropped.
- Arithmetic is modulo 2^XLEN; carries and overflow are discarded.
- lsu_addr = (rs1 + imm) with bits [1:0] cleared; misalignment is silently ignored.
- Branches: taken target = pc + B-imm; not taken = pc + 4.
- jal/jalr write pc + 4 to rd. The jalr target has bit 0 cleared.
- Request outputs (addr, wen, wdata, wmask) stay stable while valid=1 and ready=0.
- Responses arriving outside IWAIT/MWAIT are ignored.

## Timing
- Reset (rst=0), asynchronously:
  - state=FETCH, pc=RESET_PC, all registers 0.
  - retire, halt, illegal = 0.
  - ifu_req_valid and lsu_req_valid forced to 0 while rst=0.
  - lsu_addr, lsu_wdata, lsu_wen, lsu_wmask = 0.
- First ifu_req_valid=1 is in the first cycle after rst deasserts.
- Earliest ifu_rsp_valid is one cycle after the request handshake. A response in the same cycle as the handshake is ignored.
- Minimum latency, counted as cycles from entering FETCH to the retire pulse with zero wait states:
  - ALU, jump or branch: 3 (FETCH, IWAIT, EXEC).
  - lw or sw: 5 (FETCH, IWAIT, EXEC, MREQ, MWAIT).
- retire, the pc update and the register write share the same clock edge. pc shows the new value in the following cycle.
- halt and illegal assert on the edge leaving EXEC and stay set until reset.
- Reset asserted mid-transaction (MREQ/MWAIT/IWAIT) aborts the transaction immediately. A late response after reset is ignored because the FSM is in FETCH.
- Handshake fires on valid & ready at a rising edge; valid never drops before ready.

## Test plan
- Reset: hold rst=0 for 3 cycles → all outputs 0 and pc=0x8000_0000. Release → ifu_req_valid=1 and ifu_addr=0x8000_0000 in the next cycle.
- ALU: addi x1,x0,5 (0x00500093), then add x2,x1,x1 (0x00108133), zero wait states → retire every 3 cycles, x1=5, x2=10, third fetch at 0x8000_0008.
- Backpressure: ifu_req_ready=0 for 4 cycles → ifu_req_valid=1 and ifu_addr constant throughout. Then lsu_rsp_valid delayed 3 cycles → no retire until it arrives.
- Memory: x1=5, then sw x1,8(x0) (0x00102423) → lsu_wen=1, lsu_addr=0x8, lsu_wdata=5, lsu_wmask=4'hF. Then lw x2,8(x0) (0x00802103) with lsu_rdata=5 → x2=5.
- Control flow: jal x1,16 (0x010000ef) at 0x8000_0000 → x1=0x8000_0004, next fetch 0x8000_0010. Then jalr x0,1(x1) (0x00108067) → next fetch 0x8000_0004. Then bne x0,x0,8 → not taken, pc+4.
- Halt: ebreak (0x00100073) → halt=1, illegal=0, no further requests for 20 cycles. Opcode 0x0000000b → halt=1, illegal=1. With NR_REGS=16, addi x20,x0,1 → illegal=1. Reset asserted during MWAIT → back to FETCH at RESET_PC.

Source files
------------

// File: rtl/ysyx_23060278_mcore_if.sv
// Instruction-fetch and data-memory valid/ready buses of the multi-cycle core.
// master = core side, slave = memory/harness side.
interface ysyx_23060278_mcore_if #(
    parameter int XLEN = 32
) ();
    logic            ifu_req_valid;
    logic            ifu_req_ready;
    logic [XLEN-1:0] ifu_addr;
    logic            ifu_rsp_valid;
    logic [31:0]     ifu_inst;

    logic            lsu_req_valid;
    logic            lsu_req_ready;
    logic            lsu_wen;
    logic [XLEN-1:0] lsu_addr;
    logic [XLEN-1:0] lsu_wdata;
    logic [3:0]      lsu_wmask;
    logic            lsu_rsp_valid;
    logic [XLEN-1:0] lsu_rdata;

    modport master (
        output ifu_req_valid, ifu_addr,
        input  ifu_req_ready, ifu_rsp_valid, ifu_inst,
        output lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
        input  lsu_req_ready, lsu_rsp_valid, lsu_rdata
    );

    modport slave (
        input  ifu_req_valid, ifu_addr,
        output ifu_req_ready, ifu_rsp_valid, ifu_inst,
        input  lsu_req_valid, lsu_wen, lsu_addr, lsu_wdata, lsu_wmask,
        output lsu_req_ready, lsu_rsp_valid, lsu_rdata
    );
endinterface

// File: rtl/ysyx_23060278_mcore.sv
// Multi-cycle RV32I/RV32E core: FSM-sequenced fetch, execute and memory access
// over two valid/ready ports, plus halt/retire status and a debug register read.
module ysyx_23060278_mcore #(
    parameter int              XLEN     = 32,
    parameter int              NR_REGS  = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h8000_0000
) (
    input  logic                  clk,
    input  logic                  rst,
    ysyx_23060278_mcore_if.master bus,
    output logic [XLEN-1:0]       pc,
    output logic                  retire,
    output logic                  halt,
    output logic                  illegal,
    input  logic [4:0]            dbg_raddr,
    output logic [XLEN-1:0]       dbg_rdata
);
    localparam int         RW     = (NR_REGS > 16) ? 5 : 4;
    localparam logic [5:0] NR_LIM = 6'(NR_REGS);

    typedef enum logic [2:0] {
        S_FETCH = 3'd0, S_IWAIT = 3'd1, S_EXEC = 3'd2,
        S_MREQ  = 3'd3, S_MWAIT = 3'd4, S_HALT = 3'd5
    } state_t;

    state_t          state_r, next_s;
    logic [XLEN-1:0] pc_r, lsu_addr_r, lsu_wdata_r;
    logic [31:0]     inst_r;
    logic            retire_r, halt_r, illegal_r, lsu_wen_r;
    logic [3:0]      lsu_wmask_r;
    logic [XLEN-1:0] rf_r [NR_REGS];

    function automatic logic reg_ok(input logic [4:0] idx);
        return ({1'b0, idx} < NR_LIM);
    endfunction

    logic [6:0]      opcode_s, funct7_s;
    logic [2:0]      funct3_s;
    logic [4:0]      rd_s, rs1_s, rs2_s;
    logic [XLEN-1:0] imm_i_s, imm_s_s, imm_b_s, imm_u_s, imm_j_s;
    logic [XLEN-1:0] rs1_val_s, rs2_val_s;

    assign opcode_s  = inst_r[6:0];
    assign rd_s      = inst_r[11:7];
    assign funct3_s  = inst_r[14:12];
    assign rs1_s     = inst_r[19:15];
    assign rs2_s     = inst_r[24:20];
    assign funct7_s  = inst_r[31:25];
    assign imm_i_s   = {{20{inst_r[31]}}, inst_r[31:20]};
    assign imm_s_s   = {{20{inst_r[31]}}, inst_r[31:25], inst_r[11:7]};
    assign imm_b_s   = {{19{inst_r[31]}}, inst_r[31], inst_r[7], inst_r[30:25], inst_r[11:8], 1'b0};
    assign imm_u_s   = {inst_r[31:12], 12'h000};
    assign imm_j_s   = {{11{inst_r[31]}}, inst_r[31], inst_r[19:12], inst_r[20], inst_r[30:21], 1'b0};
    assign rs1_val_s = (rs1_s != 5'd0 && reg_ok(rs1_s)) ? rf_r[rs1_s[RW-1:0]] : {XLEN{1'b0}};
    assign rs2_val_s = (rs2_s != 5'd0 && reg_ok(rs2_s)) ? rf_r[rs2_s[RW-1:0]] : {XLEN{1'b0}};

    logic            legal_s, ebreak_s, is_mem_s, is_store_s, wb_en_s, stop_s, illegal_inst_s;
    logic            use_rd_s, use_rs1_s, use_rs2_s;
    logic [XLEN-1:0] wb_val_s, npc_s, mem_addr_s;

    // Decode, ALU and next-PC for the latched instruction
    always_comb begin
        legal_s    = 1'b0;
        ebreak_s   = 1'b0;
        is_mem_s   = 1'b0;
        is_store_s = 1'b0;
        wb_en_s    = 1'b0;
        use_rd_s   = 1'b0;
        use_rs1_s  = 1'b0;
        use_rs2_s  = 1'b0;
        wb_val_s   = {XLEN{1'b0}};
        npc_s      = pc_r + 32'd4;
        mem_addr_s = rs1_val_s + imm_i_s;
        case (opcode_s)
            7'b0110111: begin legal_s = 1'b1; use_rd_s = 1'b1; wb_en_s = 1'b1; wb_val_s = imm_u_s; end
            7'b0010111: begin legal_s = 1'b1; use_rd_s = 1'b1; wb_en_s = 1'b1; wb_val_s = pc_r + imm_u_s; end
            7'b1101111: begin
                legal_s = 1'b1; use_rd_s = 1'b1; wb_en_s = 1'b1;
                wb_val_s = pc_r + 32'd4;
                npc_s    = pc_r + imm_j_s;
            end
            7'b1100111: begin
                legal_s = (funct3_s == 3'b000); use_rd_s = 1'b1; use_rs1_s = 1'b1; wb_en_s = 1'b1;
                wb_val_s = pc_r + 32'd4;
                npc_s    = (rs1_val_s + imm_i_s) & ~32'd1;
            end
            7'b1100011: begin
                legal_s = (funct3_s[2:1] == 2'b00); use_rs1_s = 1'b1; use_rs2_s = 1'b1;
                // funct3[0] distinguishes bne from beq
                if ((rs1_val_s == rs2_val_s) ^ funct3_s[0]) npc_s = pc_r + imm_b_s;
                else                                          npc_s = pc_r + 32'd4;
            end
            7'b0010011: begin
                legal_s = (funct3_s == 3'b000); use_rd_s = 1'b1; use_rs1_s = 1'b1; wb_en_s = 1'b1;
                wb_val_s = rs1_val_s + imm_i_s;
            end
            7'b0110011: begin
                legal_s = (funct3_s == 3'b000) && (funct7_s == 7'b0000000 || funct7_s == 7'b0100000);
                use_rd_s = 1'b1; use_rs1_s = 1'b1; use_rs2_s = 1'b1; wb_en_s = 1'b1;
                if (funct7_s[5]) wb_val_s = rs1_val_s - rs2_val_s;
                else             wb_val_s = rs1_val_s + rs2_val_s;
            end
            7'b0000011: begin
                legal_s = (funct3_s == 3'b010); is_mem_s = 1'b1; use_rd_s = 1'b1; use_rs1_s = 1'b1;
            end
            7'b0100011: begin
                legal_s = (funct3_s == 3'b010); is_mem_s = 1'b1; is_store_s = 1'b1;
                use_rs1_s = 1'b1; use_rs2_s = 1'b1;
                mem_addr_s = rs1_val_s + imm_s_s;
            end
            7'b1110011: begin
                if (inst_r == 32'h0010_0073) ebreak_s = 1'b1;
                else                         ebreak_s = 1'b0;
            end
            default: legal_s = 1'b0;
        endcase
    end

    // RV32E rejects any register field the format actually uses beyond x15
    assign illegal_inst_s = !ebreak_s && (!legal_s || (use_rd_s && !reg_ok(rd_s)) ||
                            (use_rs1_s && !reg_ok(rs1_s)) || (use_rs2_s && !reg_ok(rs2_s)));
    assign stop_s = ebreak_s || illegal_inst_s;

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_r <= S_FETCH;
        else      state_r <= next_s;
    end

    // Next-state logic
    always_comb begin
        next_s = state_r;
        case (state_r)
            S_FETCH: if (bus.ifu_req_ready) next_s = S_IWAIT; else next_s = S_FETCH;
            S_IWAIT: if (bus.ifu_rsp_valid) next_s = S_EXEC;  else next_s = S_IWAIT;
            S_EXEC: begin
                if (stop_s)        next_s = S_HALT;
                else if (is_mem_s) next_s = S_MREQ;
                else               next_s = S_FETCH;
            end
            S_MREQ:  if (bus.lsu_req_ready) next_s = S_MWAIT; else next_s = S_MREQ;
            S_MWAIT: if (bus.lsu_rsp_valid) next_s = S_FETCH; else next_s = S_MWAIT;
            S_HALT:  next_s = S_HALT;
            default: next_s = S_FETCH;
        endcase
    end

    // PC, instruction latch, status flags and latched memory request
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_r        <= RESET_PC;
            inst_r      <= 32'h0000_0000;
            retire_r    <= 1'b0;
            halt_r      <= 1'b0;
            illegal_r   <= 1'b0;
            lsu_wen_r   <= 1'b0;
            lsu_addr_r  <= {XLEN{1'b0}};
            lsu_wdata_r <= {XLEN{1'b0}};
            lsu_wmask_r <= 4'h0;
        end else begin
            retire_r <= 1'b0;
            case (state_r)
                S_IWAIT: if (bus.ifu_rsp_valid) inst_r <= bus.ifu_inst;
                S_EXEC: begin
                    if (stop_s) begin
                        halt_r    <= 1'b1;
                        illegal_r <= illegal_inst_s;
                    end else if (is_mem_s) begin
                        lsu_wen_r   <= is_store_s;
                        lsu_addr_r  <= {mem_addr_s[XLEN-1:2], 2'b00};
                        lsu_wdata_r <= is_store_s ? rs2_val_s : {XLEN{1'b0}};
                        lsu_wmask_r <= is_store_s ? 4'hF : 4'h0;
                    end else begin
                        pc_r     <= npc_s;
                        retire_r <= 1'b1;
                    end
                end
                S_MWAIT: begin
                    if (bus.lsu_rsp_valid) begin
                        pc_r     <= pc_r + 32'd4;
                        retire_r <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    logic            rf_we_s;
    logic [XLEN-1:0] rf_wd_s;

    // Register write port: ALU result in EXEC, load data in MWAIT
    always_comb begin
        rf_we_s = 1'b0;
        rf_wd_s = wb_val_s;
        if (state_r == S_EXEC && wb_en_s && !stop_s) begin
            rf_we_s = 1'b1;
        end else if (state_r == S_MWAIT && bus.lsu_rsp_valid && !lsu_wen_r) begin
            rf_we_s = 1'b1;
            rf_wd_s = bus.lsu_rdata;
        end else begin
            rf_we_s = 1'b0;
        end
    end

    // Register file; x0 is never written so it stays zero
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NR_REGS; i++) rf_r[i] <= {XLEN{1'b0}};
        end else if (rf_we_s && rd_s != 5'd0 && reg_ok(rd_s)) begin
            rf_r[rd_s[RW-1:0]] <= rf_wd_s;
        end
    end

    // Request valids are gated by rst so they drop the moment reset asserts
    assign bus.ifu_req_valid = rst && (state_r == S_FETCH);
    assign bus.ifu_addr      = pc_r;
    assign bus.lsu_req_valid = rst && (state_r == S_MREQ);
    assign bus.lsu_wen       = lsu_wen_r;
    assign bus.lsu_addr      = lsu_addr_r;
    assign bus.lsu_wdata     = lsu_wdata_r;
    assign bus.lsu_wmask     = lsu_wmask_r;
    assign pc                = pc_r;
    assign retire            = retire_r;
    assign halt              = halt_r;
    assign illegal           = illegal_r;
    assign dbg_rdata = (dbg_raddr != 5'd0 && reg_ok(dbg_raddr)) ? rf_r[dbg_raddr[RW-1:0]] : {XLEN{1'b0}};
endmodule

// File: tb/tb_ysyx_23060278_mcore.sv
// Scoreboard bench for ysyx_23060278_mcore: RV32I instance plus an RV32E instance
// sharing stimulus, with outputs observed through a selector.
module tb_ysyx_23060278_mcore;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sel = 1'b0;
    logic ifu_req_ready = 1'b0, ifu_rsp_valid = 1'b0, lsu_req_ready = 1'b0, lsu_rsp_valid = 1'b0;
    logic [31:0] ifu_inst = 32'h0, lsu_rdata = 32'h0;
    logic [4:0]  dbg_raddr = 5'd0;
    int errors = 0, checks = 0, cyc = 0, fetch_cyc = 0;

    typedef struct packed { logic wen; logic [31:0] addr; logic [31:0] wdata; logic [3:0] mask; } lsu_exp_t;
    logic [31:0] fetch_q[$];
    logic [31:0] ret_q[$];
    lsu_exp_t    lsu_q[$];

    ysyx_23060278_mcore_if #(.XLEN(32)) bus0 ();
    ysyx_23060278_mcore_if #(.XLEN(32)) bus1 ();
    logic [31:0] pc0, pc1, dbg0, dbg1;
    logic ret0, ret1, halt0, halt1, ill0, ill1;

    ysyx_23060278_mcore #(.XLEN(32), .NR_REGS(32), .RESET_PC(32'h8000_0000)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0), .pc(pc0), .retire(ret0), .halt(halt0),
        .illegal(ill0), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg0));
    ysyx_23060278_mcore #(.XLEN(32), .NR_REGS(16), .RESET_PC(32'h8000_0000)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1), .pc(pc1), .retire(ret1), .halt(halt1),
        .illegal(ill1), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg1));

    assign bus0.ifu_req_ready = ifu_req_ready;  assign bus1.ifu_req_ready = ifu_req_ready;
    assign bus0.ifu_rsp_valid = ifu_rsp_valid;  assign bus1.ifu_rsp_valid = ifu_rsp_valid;
    assign bus0.ifu_inst      = ifu_inst;       assign bus1.ifu_inst      = ifu_inst;
    assign bus0.lsu_req_ready = lsu_req_ready;  assign bus1.lsu_req_ready = lsu_req_ready;
    assign bus0.lsu_rsp_valid = lsu_rsp_valid;  assign bus1.lsu_rsp_valid = lsu_rsp_valid;
    assign bus0.lsu_rdata     = lsu_rdata;      assign bus1.lsu_rdata     = lsu_rdata;

    logic ifu_req_valid_m, lsu_req_valid_m, lsu_wen_m, retire_m, halt_m, illegal_m;
    logic [31:0] ifu_addr_m, lsu_addr_m, lsu_wdata_m, pc_m, dbg_rdata_m;
    logic [3:0]  lsu_wmask_m;
    assign ifu_req_valid_m = sel ? bus1.ifu_req_valid : bus0.ifu_req_valid;
    assign ifu_addr_m      = sel ? bus1.ifu_addr      : bus0.ifu_addr;
    assign lsu_req_valid_m = sel ? bus1.lsu_req_valid : bus0.lsu_req_valid;
    assign lsu_wen_m       = sel ? bus1.lsu_wen       : bus0.lsu_wen;
    assign lsu_addr_m      = sel ? bus1.lsu_addr      : bus0.lsu_addr;
    assign lsu_wdata_m     = sel ? bus1.lsu_wdata     : bus0.lsu_wdata;
    assign lsu_wmask_m     = sel ? bus1.lsu_wmask     : bus0.lsu_wmask;
    assign pc_m            = sel ? pc1   : pc0;
    assign retire_m        = sel ? ret1  : ret0;
    assign halt_m          = sel ? halt1 : halt0;
    assign illegal_m       = sel ? ill1  : ill0;
    assign dbg_rdata_m     = sel ? dbg1  : dbg0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic clear_inputs();
        ifu_req_ready = 1'b0; ifu_rsp_valid = 1'b0; lsu_req_ready = 1'b0; lsu_rsp_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        clear_inputs();
        repeat (3) @(negedge clk);
        rst = 1'b1;
        fetch_q.delete(); ret_q.delete(); lsu_q.delete();
    endtask

    task automatic check_reg(input logic [4:0] idx, input logic [31:0] exp);
        dbg_raddr = idx;
        #1;
        checks++;
        if (dbg_rdata_m !== exp) begin
            errors++;
            $display("FAIL reg_x%0d: got %h, required %h", idx, dbg_rdata_m, exp);
        end
    endtask

    // Waits for a fetch request, checks its address, optionally stalls it, then returns inst.
    task automatic serve_fetch(input logic [31:0] inst, input int stall, input bit junk);
        int n = 0;
        logic [31:0] exp_a, a0;
        while (ifu_req_valid_m !== 1'b1 && n < 50) begin @(negedge clk); n++; end
        checks++;
        if (ifu_req_valid_m !== 1'b1) begin
            errors++;
            $display("FAIL fetch_timeout: got valid=%b, required 1", ifu_req_valid_m);
        end
        exp_a = fetch_q.pop_front();
        fetch_cyc = cyc;
        a0 = ifu_addr_m;
        checks++;
        if (ifu_addr_m !== exp_a) begin
            errors++;
            $display("FAIL fetch_addr: got %h, required %h", ifu_addr_m, exp_a);
        end
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            checks++;
            if (ifu_req_valid_m !== 1'b1 || ifu_addr_m !== a0) begin
                errors++;
                $display("FAIL fetch_hold: got valid=%b addr=%h, required 1/%h", ifu_req_valid_m, ifu_addr_m, a0);
            end
        end
        ifu_req_ready = 1'b1;
        if (junk) begin ifu_rsp_valid = 1'b1; ifu_inst = 32'h0000_000b; end
        @(negedge clk);
        ifu_req_ready = 1'b0;
        ifu_rsp_valid = 1'b1;
        ifu_inst = inst;
        @(negedge clk);
        ifu_rsp_valid = 1'b0;
    endtask

    task automatic check_retired(input int lat);
        logic [31:0] ep;
        ep = ret_q.pop_front();
        checks++;
        if (retire_m !== 1'b1) begin errors++; $display("FAIL retire_pulse: got %b, required 1", retire_m); end
        checks++;
        if (pc_m !== ep) begin errors++; $display("FAIL retire_pc: got %h, required %h", pc_m, ep); end
        checks++;
        if (cyc - fetch_cyc != lat) begin
            errors++;
            $display("FAIL latency: got %0d cycles, required %0d", cyc - fetch_cyc, lat);
        end
    endtask

    task automatic run_alu(input logic [31:0] inst, input int stall, input bit junk);
        serve_fetch(inst, stall, junk);
        checks++;
        if (retire_m !== 1'b0) begin errors++; $display("FAIL early_retire: got %b, required 0", retire_m); end
        @(negedge clk);
        check_retired(3 + stall);
    endtask

    task automatic run_mem(input logic [31:0] inst, input int istall, input int mstall,
                           input int rdelay, input logic [31:0] rdata);
        lsu_exp_t e;
        serve_fetch(inst, istall, 1'b0);
        e = lsu_q.pop_front();
        for (int i = 0; i <= mstall; i++) begin
            @(negedge clk);
            checks++;
            if (lsu_req_valid_m !== 1'b1 || lsu_wen_m !== e.wen || lsu_addr_m !== e.addr ||
                lsu_wmask_m !== e.mask || (e.wen && lsu_wdata_m !== e.wdata)) begin
                errors++;
                $display("FAIL lsu_req: got v=%b wen=%b addr=%h wdata=%h mask=%h, required 1/%b/%h/%h/%h",
                         lsu_req_valid_m, lsu_wen_m, lsu_addr_m, lsu_wdata_m, lsu_wmask_m,
                         e.wen, e.addr, e.wdata, e.mask);
            end
        end
        lsu_req_ready = 1'b1;
        @(negedge clk);
        lsu_req_ready = 1'b0;
        for (int i = 0; i < rdelay; i++) begin
            checks++;
            if (retire_m !== 1'b0) begin errors++; $display("FAIL mwait_retire: got %b, required 0", retire_m); end
            @(negedge clk);
        end
        lsu_rsp_valid = 1'b1;
        lsu_rdata = rdata;
        @(negedge clk);
        lsu_rsp_valid = 1'b0;
        check_retired(5 + istall + mstall + rdelay);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #2 rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (ifu_req_valid_m !== 1'b0 || lsu_req_valid_m !== 1'b0 || retire_m !== 1'b0 ||
            halt_m !== 1'b0 || illegal_m !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags: got iv=%b lv=%b ret=%b halt=%b ill=%b, required all 0",
                     ifu_req_valid_m, lsu_req_valid_m, retire_m, halt_m, illegal_m);
        end
        checks++;
        if (lsu_addr_m !== 32'h0 || lsu_wdata_m !== 32'h0 || lsu_wen_m !== 1'b0 || lsu_wmask_m !== 4'h0) begin
            errors++;
            $display("FAIL reset_lsu: got addr=%h wdata=%h wen=%b mask=%h, required 0", lsu_addr_m,
                     lsu_wdata_m, lsu_wen_m, lsu_wmask_m);
        end
        checks++;
        if (pc_m !== 32'h8000_0000) begin errors++; $display("FAIL reset_pc: got %h, required 80000000", pc_m); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (ifu_req_valid_m !== 1'b1 || ifu_addr_m !== 32'h8000_0000) begin
            errors++;
            $display("FAIL first_fetch: got v=%b addr=%h, required 1/80000000", ifu_req_valid_m, ifu_addr_m);
        end
    endtask

    task automatic test_alu();
        logic [31:0] prog [6] = '{32'h00500093, 32'h00108133, 32'h123452B7,
                                  32'h00001317, 32'h406283B3, 32'h00700013};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            fetch_q.push_back(32'h8000_0000 + 32'(4 * i));
            ret_q.push_back(32'h8000_0004 + 32'(4 * i));
            run_alu(prog[i], 0, (i == 2));
        end
        check_reg(5'd1, 32'd5);
        check_reg(5'd2, 32'd10);
        check_reg(5'd5, 32'h1234_5000);
        check_reg(5'd6, 32'h8000_100C);
        check_reg(5'd7, 32'h9234_3FF4);
        check_reg(5'd0, 32'h0);
    endtask

    task automatic test_backpressure();
        do_reset();
        fetch_q.push_back(32'h8000_0000); ret_q.push_back(32'h8000_0004);
        run_alu(32'h00500093, 4, 1'b0);
        fetch_q.push_back(32'h8000_0004); ret_q.push_back(32'h8000_0008);
        lsu_q.push_back('{wen: 1'b0, addr: 32'h8, wdata: 32'h0, mask: 4'h0});
        run_mem(32'h00802103, 0, 2, 3, 32'h0000_1234);
        check_reg(5'd2, 32'h0000_1234);
    endtask

    task automatic test_memory();
        do_reset();
        fetch_q.push_back(32'h8000_0000); ret_q.push_back(32'h8000_0004);
        run_alu(32'h00500093, 0, 1'b0);
        fetch_q.push_back(32'h8000_0004); ret_q.push_back(32'h8000_0008);
        lsu_q.push_back('{wen: 1'b1, addr: 32'h8, wdata: 32'd5, mask: 4'hF});
        run_mem(32'h00102423, 0, 0, 0, 32'hFFFF_FFFF);
        fetch_q.push_back(32'h8000_0008); ret_q.push_back(32'h8000_000C);
        lsu_q.push_back('{wen: 1'b0, addr: 32'h8, wdata: 32'h0, mask: 4'h0});
        run_mem(32'h00802103, 0, 0, 0, 32'd5);
        fetch_q.push_back(32'h8000_000C); ret_q.push_back(32'h8000_0010);
        lsu_q.push_back('{wen: 1'b0, addr: 32'hC, wdata: 32'h0, mask: 4'h0});
        run_mem(32'h0070A183, 0, 0, 1, 32'hDEAD_BEEF);
        check_reg(5'd2, 32'd5);
        check_reg(5'd3, 32'hDEAD_BEEF);
        check_reg(5'd8, 32'h0);
    endtask

    task automatic test_control();
        logic [31:0] prog [4] = '{32'h010000ef, 32'h00108067, 32'h00001463, 32'hFE000CE3};
        logic [31:0] at   [4] = '{32'h8000_0000, 32'h8000_0010, 32'h8000_0004, 32'h8000_0008};
        logic [31:0] nxt  [4] = '{32'h8000_0010, 32'h8000_0004, 32'h8000_0008, 32'h8000_0000};
        do_reset();
        for (int i = 0; i < 4; i++) begin
            fetch_q.push_back(at[i]); ret_q.push_back(nxt[i]);
            run_alu(prog[i], 0, 1'b0);
        end
        check_reg(5'd1, 32'h8000_0004);
        fetch_q.push_back(32'h8000_0000);
        checks++;
        if (ifu_req_valid_m !== 1'b1 || ifu_addr_m !== fetch_q[0]) begin
            errors++;
            $display("FAIL branch_refetch: got v=%b addr=%h, required 1/%h", ifu_req_valid_m, ifu_addr_m, fetch_q[0]);
        end
        void'(fetch_q.pop_front());
    endtask

    task automatic test_halt();
        int viol = 0;
        do_reset();
        fetch_q.push_back(32'h8000_0000);
        serve_fetch(32'h0010_0073, 0, 1'b0);
        @(negedge clk);
        checks++;
        if (halt_m !== 1'b1 || illegal_m !== 1'b0 || retire_m !== 1'b0) begin
            errors++;
            $display("FAIL ebreak_halt: got halt=%b ill=%b ret=%b, required 1/0/0", halt_m, illegal_m, retire_m);
        end
        ifu_req_ready = 1'b1; lsu_req_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            ifu_rsp_valid = i[0];
            lsu_rsp_valid = ~i[0];
            if (ifu_req_valid_m || lsu_req_valid_m || retire_m || !halt_m) viol++;
        end
        clear_inputs();
        checks++;
        if (viol != 0) begin errors++; $display("FAIL halt_quiet: got %0d bad cycles, required 0", viol); end
        do_reset();
        fetch_q.push_back(32'h8000_0000);
        serve_fetch(32'h0000_000b, 0, 1'b0);
        @(negedge clk);
        checks++;
        if (halt_m !== 1'b1 || illegal_m !== 1'b1 || retire_m !== 1'b0) begin
            errors++;
            $display("FAIL illegal_halt: got halt=%b ill=%b ret=%b, required 1/1/0", halt_m, illegal_m, retire_m);
        end
    endtask

    task automatic test_rv32e();
        sel = 1'b1;
        do_reset();
        fetch_q.push_back(32'h8000_0000); ret_q.push_back(32'h8000_0004);
        run_alu(32'h00700293, 0, 1'b0);
        check_reg(5'd5, 32'd7);
        fetch_q.push_back(32'h8000_0004);
        serve_fetch(32'h00100A13, 0, 1'b0);
        @(negedge clk);
        checks++;
        if (halt_m !== 1'b1 || illegal_m !== 1'b1 || retire_m !== 1'b0) begin
            errors++;
            $display("FAIL rv32e_illegal: got halt=%b ill=%b ret=%b, required 1/1/0", halt_m, illegal_m, retire_m);
        end
        check_reg(5'd20, 32'h0);
        sel = 1'b0;
    endtask

    task automatic test_reset_mwait();
        lsu_exp_t e;
        do_reset();
        fetch_q.push_back(32'h8000_0000); ret_q.push_back(32'h8000_0004);
        run_alu(32'h00500093, 0, 1'b0);
        fetch_q.push_back(32'h8000_0004);
        lsu_q.push_back('{wen: 1'b0, addr: 32'h8, wdata: 32'h0, mask: 4'h0});
        serve_fetch(32'h00802103, 0, 1'b0);
        @(negedge clk);
        e = lsu_q.pop_front();
        checks++;
        if (lsu_req_valid_m !== 1'b1 || lsu_addr_m !== e.addr) begin
            errors++;
            $display("FAIL mreq: got v=%b addr=%h, required 1/%h", lsu_req_valid_m, lsu_addr_m, e.addr);
        end
        lsu_req_ready = 1'b1;
        @(negedge clk);
        lsu_req_ready = 1'b0;
        rst = 1'b0;
        #1;
        checks++;
        if (pc_m !== 32'h8000_0000 || lsu_addr_m !== 32'h0 || ifu_req_valid_m !== 1'b0) begin
            errors++;
            $display("FAIL mwait_reset: got pc=%h laddr=%h iv=%b, required 80000000/0/0", pc_m, lsu_addr_m, ifu_req_valid_m);
        end
        @(negedge clk);
        rst = 1'b1;
        lsu_rsp_valid = 1'b1;
        lsu_rdata = 32'h0000_0BAD;
        @(negedge clk);
        lsu_rsp_valid = 1'b0;
        checks++;
        if (retire_m !== 1'b0 || ifu_req_valid_m !== 1'b1 || ifu_addr_m !== 32'h8000_0000) begin
            errors++;
            $display("FAIL late_rsp: got ret=%b iv=%b addr=%h, required 0/1/80000000", retire_m, ifu_req_valid_m, ifu_addr_m);
        end
        check_reg(5'd1, 32'h0);
        check_reg(5'd2, 32'h0);
    endtask

    initial begin
        test_reset();
        test_alu();
        test_backpressure();
        test_memory();
        test_control();
        test_halt();
        test_rv32e();
        test_reset_mwait();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
